// File: rtl/rx_sync_fifo.sv
// Receive-side synchronous FIFO: show-ahead head word, registered
// occupancy flags, sticky overflow when a word arrives while full.
module rx_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk_rx,
    input  logic              reset,
    input  logic [DATA_W-1:0] rdata,
    input  logic              vo,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count,
    output logic              ovf
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic              push;
        logic              pop;
        logic              drop;
    } xfer_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_nxt;
    xfer_t             xf;

    // Decode this edge's transfer; a pop frees the slot a full-FIFO write needs.
    always_comb begin
        xf      = '0;
        xf.pop  = rd_en & ~empty;
        xf.push = vo & (~full | xf.pop);
        xf.drop = vo & full & ~xf.pop;
        count_nxt = count;
        if (xf.push && !xf.pop)
            count_nxt = count + (AW+1)'(1);
        else if (xf.pop && !xf.push)
            count_nxt = count - (AW+1)'(1);
    end

    // Storage array; contents are don't-care until written, so never reset.
    always_ff @(posedge clk_rx) begin
        if (reset && xf.push)
            mem[wr_ptr] <= rdata;
    end

    // Pointers, occupancy and sticky overflow; set beats clear on the same edge.
    always_ff @(posedge clk_rx) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            if (xf.push) wr_ptr <= wr_ptr + AW'(1);
            if (xf.pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == FULL_CNT);
            if (xf.drop)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    // Head word is visible the cycle after it is written; zero when empty.
    assign dout   = empty ? '0 : mem[rd_ptr];
    assign dvalid = ~empty;

endmodule
